// File: rtl/modulo_arbiter.sv
// Two-requester round-robin front end for a shared, sticky-output modulo unit.
// One operation in flight; zero divisors bypass the unit, and a stalled unit times out.
module modulo_arbiter #(
    parameter int SIZE    = 64,
    parameter int TIMEOUT = 4096
) (
    input  logic            clk,
    input  logic            rst,

    input  logic [SIZE-1:0] req0_dividen_tdata,
    input  logic [SIZE-1:0] req0_divisor_tdata,
    input  logic            req0_tvalid,
    output logic            req0_tready,
    input  logic [SIZE-1:0] req1_dividen_tdata,
    input  logic [SIZE-1:0] req1_divisor_tdata,
    input  logic            req1_tvalid,
    output logic            req1_tready,

    output logic [SIZE-1:0] res0_tdata,
    output logic            res0_terr,
    output logic            res0_tvalid,
    input  logic            res0_tready,
    output logic [SIZE-1:0] res1_tdata,
    output logic            res1_terr,
    output logic            res1_tvalid,
    input  logic            res1_tready,

    output logic [SIZE-1:0] mod_dividen_tdata,
    output logic [SIZE-1:0] mod_divisor_tdata,
    output logic            mod_dividen_tvalid,
    output logic            mod_divisor_tvalid,
    input  logic [SIZE-1:0] mod_out_tdata,
    input  logic            mod_out_tvalid,
    output logic            mod_out_tready,
    output logic            mod_rst
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CLEAR, RESP} state_t;

    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

    state_t          state;
    state_t          state_next;
    logic            last_grant;
    logic            grant;
    logic [SIZE-1:0] dividend_q;
    logic [SIZE-1:0] divisor_q;
    logic [SIZE-1:0] result_q;
    logic            err_q;
    logic [15:0]     wait_cnt;

    logic            any_req;
    logic            pick1;
    logic [SIZE-1:0] sel_dividend;
    logic [SIZE-1:0] sel_divisor;
    logic            resp_done;
    logic            wait_expired;

    // On a tie the requester that was not served last wins.
    always_comb begin
        any_req      = req0_tvalid | req1_tvalid;
        pick1        = (req0_tvalid && req1_tvalid) ? ~last_grant : req1_tvalid;
        sel_dividend = pick1 ? req1_dividen_tdata : req0_dividen_tdata;
        sel_divisor  = pick1 ? req1_divisor_tdata : req0_divisor_tdata;
        resp_done    = grant ? res1_tready : res0_tready;
        wait_expired = (wait_cnt == LAST_WAIT);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (any_req) state_next = (sel_divisor == '0) ? RESP : ISSUE;
            ISSUE: state_next = WAIT;
            WAIT:  if (mod_out_tvalid || wait_expired) state_next = CLEAR;
            CLEAR: state_next = RESP;
            RESP:  if (resp_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant      <= pick1;
                        dividend_q <= sel_dividend;
                        divisor_q  <= sel_divisor;
                        result_q   <= '0;
                        err_q      <= (sel_divisor == '0);
                    end
                end
                ISSUE: wait_cnt <= '0;
                WAIT: begin
                    wait_cnt <= wait_cnt + 16'd1;
                    // A late result still wins over the timeout in the same cycle.
                    if (mod_out_tvalid) begin
                        result_q <= mod_out_tdata;
                        err_q    <= 1'b0;
                    end else if (wait_expired) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                    end
                end
                RESP: if (resp_done) last_grant <= grant;
                default: ;
            endcase
        end
    end

    // Every handshake output is forced low while reset is held.
    always_comb begin
        req0_tready        = !rst && (state == IDLE) && any_req && !pick1;
        req1_tready        = !rst && (state == IDLE) && any_req && pick1;
        res0_tvalid        = !rst && (state == RESP) && !grant;
        res1_tvalid        = !rst && (state == RESP) && grant;
        res0_tdata         = res0_tvalid ? result_q : '0;
        res1_tdata         = res1_tvalid ? result_q : '0;
        res0_terr          = res0_tvalid && err_q;
        res1_terr          = res1_tvalid && err_q;
        mod_dividen_tdata  = dividend_q;
        mod_divisor_tdata  = divisor_q;
        mod_dividen_tvalid = !rst && (state == ISSUE);
        mod_divisor_tvalid = !rst && (state == ISSUE);
        mod_out_tready     = !rst && (state == WAIT);
        mod_rst            = rst || (state == CLEAR);
    end

endmodule

// File: tb/tb_modulo_arbiter.sv
// Self-checking bench for modulo_arbiter: vector table, hand-written corner sequences,
// and randomized traffic against a spec-level reference model with a sticky modulo unit model.
module tb_modulo_arbiter;

    localparam int SIZE    = 64;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [SIZE-1:0] req0_dividen_tdata = '0, req0_divisor_tdata = '0;
    logic [SIZE-1:0] req1_dividen_tdata = '0, req1_divisor_tdata = '0;
    logic            req0_tvalid = 1'b0, req1_tvalid = 1'b0;
    logic            req0_tready, req1_tready;
    logic [SIZE-1:0] res0_tdata, res1_tdata;
    logic            res0_terr, res1_terr, res0_tvalid, res1_tvalid;
    logic            res0_tready = 1'b1, res1_tready = 1'b1;
    logic [SIZE-1:0] mod_dividen_tdata, mod_divisor_tdata;
    logic            mod_dividen_tvalid, mod_divisor_tvalid;
    logic [SIZE-1:0] mod_out_tdata;
    logic            mod_out_tvalid;
    logic            mod_out_tready;
    logic            mod_rst;

    int total = 0;
    int bad   = 0;

    modulo_arbiter #(.SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req0_dividen_tdata(req0_dividen_tdata), .req0_divisor_tdata(req0_divisor_tdata),
        .req0_tvalid(req0_tvalid), .req0_tready(req0_tready),
        .req1_dividen_tdata(req1_dividen_tdata), .req1_divisor_tdata(req1_divisor_tdata),
        .req1_tvalid(req1_tvalid), .req1_tready(req1_tready),
        .res0_tdata(res0_tdata), .res0_terr(res0_terr), .res0_tvalid(res0_tvalid), .res0_tready(res0_tready),
        .res1_tdata(res1_tdata), .res1_terr(res1_terr), .res1_tvalid(res1_tvalid), .res1_tready(res1_tready),
        .mod_dividen_tdata(mod_dividen_tdata), .mod_divisor_tdata(mod_divisor_tdata),
        .mod_dividen_tvalid(mod_dividen_tvalid), .mod_divisor_tvalid(mod_divisor_tvalid),
        .mod_out_tdata(mod_out_tdata), .mod_out_tvalid(mod_out_tvalid), .mod_out_tready(mod_out_tready),
        .mod_rst(mod_rst)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Modulo unit model: answers model_delay cycles after the operand pulse, never if 0;
    // its valid stays high until mod_rst.
    int              model_delay = 1;
    int              unit_cnt    = 0;
    logic            unit_valid  = 1'b0;
    logic [SIZE-1:0] unit_data   = '0;
    assign mod_out_tvalid = unit_valid;
    assign mod_out_tdata  = unit_data;

    always @(posedge clk) begin
        if (mod_rst) begin
            unit_valid <= 1'b0;
            unit_cnt   <= 0;
        end else if (mod_dividen_tvalid) begin
            unit_data <= (mod_divisor_tdata == '0) ? '0 : mod_dividen_tdata % mod_divisor_tdata;
            unit_cnt  <= model_delay;
        end else if (unit_cnt > 0) begin
            unit_cnt <= unit_cnt - 1;
            if (unit_cnt == 1) unit_valid <= 1'b1;
        end
    end

    // Transaction monitor: records every completed response with its latency from acceptance.
    typedef struct {
        int              who;
        logic [SIZE-1:0] data;
        logic            err;
        int              lat;
        int              issues;
        int              clears;
    } resp_t;
    resp_t resp_q[$];

    int              cyc = 0, acc_cyc = 0, first_cyc = 0, issues = 0, clears = 0, cur_who = 0;
    bit              busy = 0, in_resp = 0;
    logic [SIZE-1:0] hold_d = '0;
    logic            hold_e = 1'b0;

    always begin
        int              vw;
        logic [SIZE-1:0] vd;
        logic            ve;
        @(negedge clk);
        #2;
        cyc++;
        if (rst) begin
            busy    = 0;
            in_resp = 0;
        end else begin
            checkOutput("mod_tvalid_pair", 64'(mod_dividen_tvalid), 64'(mod_divisor_tvalid));
            checkOutput("tready_excl", 64'((req0_tready && req1_tready) || (busy && (req0_tready || req1_tready))), 64'd0);
            if (mod_dividen_tvalid) issues++;
            if (mod_rst) clears++;
            if ((req0_tvalid && req0_tready) || (req1_tvalid && req1_tready)) begin
                busy    = 1;
                cur_who = req1_tready ? 1 : 0;
                acc_cyc = cyc;
                issues  = 0;
                clears  = 0;
            end
            if (res0_tvalid || res1_tvalid) begin
                vw = res1_tvalid ? 1 : 0;
                vd = vw == 1 ? res1_tdata : res0_tdata;
                ve = vw == 1 ? res1_terr : res0_terr;
                checkOutput("res_owner", 64'(busy && vw == cur_who && !(res0_tvalid && res1_tvalid)), 64'd1);
                if (!in_resp) begin
                    in_resp   = 1;
                    first_cyc = cyc;
                    hold_d    = vd;
                    hold_e    = ve;
                end else begin
                    checkOutput("res_stable_data", vd, hold_d);
                    checkOutput("res_stable_err", 64'(ve), 64'(hold_e));
                end
                if (vw == 1 ? res1_tready : res0_tready) begin
                    resp_q.push_back('{vw, vd, ve, first_cyc - acc_cyc, issues, clears});
                    busy    = 0;
                    in_resp = 0;
                end
            end
        end
    end

    // Reference model: the remainder, or 0 with error for a zero divisor or a silent unit.
    int model_last = 1;

    function automatic logic [SIZE-1:0] refData(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input int d);
        return (b == '0 || d == 0) ? '0 : a % b;
    endfunction
    function automatic logic refErr(input logic [SIZE-1:0] b, input int d);
        return (b == '0 || d == 0);
    endfunction
    function automatic int refLat(input logic [SIZE-1:0] b, input int d);
        if (b == '0) return 1;
        if (d == 0) return TIMEOUT + 3;
        return d + 4;
    endfunction

    task automatic dropValid(input int who);
        if (who == 0) req0_tvalid = 1'b0; else req1_tvalid = 1'b0;
    endtask

    task automatic driveReq(input int who, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        if (who == 0) begin
            req0_dividen_tdata = a; req0_divisor_tdata = b; req0_tvalid = 1'b1;
        end else begin
            req1_dividen_tdata = a; req1_divisor_tdata = b; req1_tvalid = 1'b1;
        end
    endtask

    // Called at a negedge with the request already driven; returns at the negedge after acceptance.
    task automatic waitAccept(input int who, output bit ok);
        bit t;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            #2;
            t = (who == 0) ? req0_tready : req1_tready;
            @(negedge clk);
            if (t) begin
                dropValid(who);
                ok = 1;
                break;
            end
        end
        if (!ok) dropValid(who);
    endtask

    task automatic waitResp(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (resp_q.size() >= n) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic checkResp(input string tag, input int who, input logic [SIZE-1:0] ed,
                             input logic ee, input int el, input int nops);
        resp_t r;
        if (resp_q.size() == 0) begin
            checkOutput({tag, "_present"}, 64'd0, 64'd1);
            return;
        end
        r = resp_q.pop_front();
        checkOutput({tag, "_who"}, 64'(r.who), 64'(who));
        checkOutput({tag, "_data"}, r.data, ed);
        checkOutput({tag, "_err"}, 64'(r.err), 64'(ee));
        checkOutput({tag, "_latency"}, 64'(r.lat), 64'(el));
        checkOutput({tag, "_mod_pulses"}, 64'(r.issues), 64'(nops));
        checkOutput({tag, "_mod_rst_pulses"}, 64'(r.clears), 64'(nops));
    endtask

    task automatic applyStimulus(input string tag, input int who, input logic [SIZE-1:0] a,
                                 input logic [SIZE-1:0] b, input int d, input logic [SIZE-1:0] ed,
                                 input logic ee, input int el);
        bit ok;
        resp_q.delete();
        model_delay = d;
        @(negedge clk);
        driveReq(who, a, b);
        waitAccept(who, ok);
        checkOutput({tag, "_accepted"}, 64'(ok), 64'd1);
        waitResp(1, ok);
        checkOutput({tag, "_responded"}, 64'(ok), 64'd1);
        checkResp(tag, who, ed, ee, el, (b != '0) ? 1 : 0);
        model_last = who;
    endtask

    // Both requesters raise valid in the same cycle; expected service order comes from model_last.
    task automatic applyPair(input string tag, input logic [SIZE-1:0] a0, input logic [SIZE-1:0] b0,
                             input logic [SIZE-1:0] a1, input logic [SIZE-1:0] b1, input int d,
                             input int exp_first);
        bit ok, acc0, acc1, t0, t1;
        int first, second;
        logic [SIZE-1:0] af, bf, as, bs;
        first  = 1 - model_last;
        second = model_last;
        checkOutput({tag, "_first_grant"}, 64'(first), 64'(exp_first));
        resp_q.delete();
        model_delay = d;
        @(negedge clk);
        driveReq(0, a0, b0);
        driveReq(1, a1, b1);
        acc0 = 0;
        acc1 = 0;
        for (int i = 0; i < 400 && !(acc0 && acc1); i++) begin
            #2;
            t0 = req0_tready;
            t1 = req1_tready;
            @(negedge clk);
            if (t0) begin req0_tvalid = 1'b0; acc0 = 1; end
            if (t1) begin req1_tvalid = 1'b0; acc1 = 1; end
        end
        req0_tvalid = 1'b0;
        req1_tvalid = 1'b0;
        checkOutput({tag, "_both_accepted"}, 64'(acc0 && acc1), 64'd1);
        waitResp(2, ok);
        checkOutput({tag, "_responded"}, 64'(ok), 64'd1);
        af = first == 0 ? a0 : a1;  bf = first == 0 ? b0 : b1;
        as = first == 0 ? a1 : a0;  bs = first == 0 ? b1 : b0;
        checkResp({tag, "_1st"}, first, refData(af, bf, d), refErr(bf, d), refLat(bf, d), (bf != '0) ? 1 : 0);
        checkResp({tag, "_2nd"}, second, refData(as, bs, d), refErr(bs, d), refLat(bs, d), (bs != '0) ? 1 : 0);
        model_last = second;
    endtask

    typedef struct {
        int              who;
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] b;
        int              delay;
        logic [SIZE-1:0] exp_data;
        logic            exp_err;
        int              exp_lat;
    } vec_t;

    initial begin
        vec_t            vecs[8];
        bit              ok;
        int              who, d;
        logic [SIZE-1:0] a, b, a1, b1;

        vecs[0] = '{0, 64'd100, 64'd7, 5, 64'd2, 1'b0, 9};
        vecs[1] = '{1, 64'd100, 64'd7, 1, 64'd2, 1'b0, 5};
        vecs[2] = '{1, 64'd77, 64'd0, 3, 64'd0, 1'b1, 1};
        vecs[3] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 2, 64'd5, 1'b0, 6};
        vecs[4] = '{1, 64'd5, 64'd9, 3, 64'd5, 1'b0, 7};
        vecs[5] = '{0, 64'd10, 64'd3, 0, 64'd0, 1'b1, 19};
        vecs[6] = '{0, 64'd12, 64'd12, 4, 64'd0, 1'b0, 8};
        vecs[7] = '{1, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 6, 64'd1, 1'b0, 10};

        // Reset state, with a request pending to show tready is held off.
        req0_dividen_tdata = 64'd3;
        req0_divisor_tdata = 64'd2;
        req0_tvalid        = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #2;
            checkOutput("rst_req0_tready", 64'(req0_tready), 64'd0);
            checkOutput("rst_req1_tready", 64'(req1_tready), 64'd0);
            checkOutput("rst_res_tvalid", 64'(res0_tvalid | res1_tvalid), 64'd0);
            checkOutput("rst_res_terr", 64'(res0_terr | res1_terr), 64'd0);
            checkOutput("rst_res0_tdata", res0_tdata, 64'd0);
            checkOutput("rst_mod_tvalid", 64'(mod_dividen_tvalid | mod_divisor_tvalid), 64'd0);
            checkOutput("rst_mod_out_tready", 64'(mod_out_tready), 64'd0);
            checkOutput("rst_mod_rst", 64'(mod_rst), 64'd1);
        end
        @(negedge clk);
        req0_tvalid = 1'b0;
        rst         = 1'b0;
        model_last  = 1;

        // Round-robin from reset: requester 0 wins the first tie, then order alternates.
        applyPair("tie_a", 64'd50, 64'd6, 64'd9, 64'd4, 3, 0);
        applyPair("tie_b", 64'd50, 64'd6, 64'd9, 64'd4, 2, 0);
        applyStimulus("solo0", 0, 64'd21, 64'd8, 1, 64'd5, 1'b0, 5);
        applyPair("tie_c", 64'd50, 64'd6, 64'd9, 64'd4, 2, 1);

        for (int i = 0; i < 8; i++)
            applyStimulus($sformatf("vec%0d", i), vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].delay,
                          vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat);

        // Back-pressure on the result: data holds and the other requester waits.
        resp_q.delete();
        res0_tready = 1'b0;
        model_delay = 2;
        @(negedge clk);
        driveReq(0, 64'd23, 64'd5);
        waitAccept(0, ok);
        checkOutput("hold_accept", 64'(ok), 64'd1);
        driveReq(1, 64'd30, 64'd4);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            #2;
            if (res0_tvalid) begin ok = 1; break; end
            @(negedge clk);
        end
        checkOutput("hold_res_seen", 64'(ok), 64'd1);
        for (int k = 0; k < 10; k++) begin
            checkOutput("hold_res0_tvalid", 64'(res0_tvalid), 64'd1);
            checkOutput("hold_res0_tdata", res0_tdata, 64'd3);
            checkOutput("hold_res0_terr", 64'(res0_terr), 64'd0);
            checkOutput("hold_req1_tready", 64'(req1_tready), 64'd0);
            @(negedge clk);
            #2;
        end
        @(negedge clk);
        res0_tready = 1'b1;
        @(negedge clk);
        #2;
        checkOutput("release_idle_req1_tready", 64'(req1_tready), 64'd1);
        @(negedge clk);
        req1_tvalid = 1'b0;
        waitResp(2, ok);
        checkOutput("hold_both_resp", 64'(ok), 64'd1);
        checkResp("hold_r0", 0, 64'd3, 1'b0, 6, 1);
        checkResp("hold_r1", 1, 64'd2, 1'b0, 6, 1);
        model_last = 1;

        // Reset in the middle of WAIT abandons the operation without a result.
        resp_q.delete();
        model_delay = 0;
        @(negedge clk);
        driveReq(0, 64'd40, 64'd3);
        waitAccept(0, ok);
        checkOutput("midrst_accept", 64'(ok), 64'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            #2;
            checkOutput("midrst_mod_rst", 64'(mod_rst), 64'd1);
            checkOutput("midrst_res_tvalid", 64'(res0_tvalid | res1_tvalid), 64'd0);
            @(negedge clk);
        end
        rst        = 1'b0;
        model_last = 1;
        repeat (25) @(negedge clk);
        checkOutput("midrst_no_result", 64'(resp_q.size()), 64'd0);
        applyPair("post_rst_tie", 64'd100, 64'd7, 64'd17, 64'd5, 2, 0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            a  = {$urandom, $urandom};
            a1 = {$urandom, $urandom};
            b  = ($urandom_range(0, 4) == 0) ? 64'd0 :
                 ($urandom_range(0, 1) == 0) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom} | 64'd1;
            b1 = ($urandom_range(0, 4) == 0) ? 64'd0 : 64'($urandom_range(1, 100000));
            d  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            if ($urandom_range(0, 3) == 3) begin
                applyPair($sformatf("rnd%0d_pair", n), a, b, a1, b1, d, 1 - model_last);
            end else begin
                who = $urandom_range(0, 1);
                applyStimulus($sformatf("rnd%0d", n), who, a, b, d, refData(a, b, d), refErr(b, d), refLat(b, d));
            end
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
